// File: rtl/atm_session_ctrl.sv
// ATM session controller: owns the per-account PIN/balance tables and lock
// flags, validates cards, verifies PINs with bounded retries, enforces an
// inactivity timeout and commits balances from the transaction datapath.
//
// Input handshake: every request input (card_in, card_out, psw_valid,
// op_done, prov_we) is a single-cycle strobe sampled on the rising clock
// edge with its data bus valid in that same cycle. There is no back-pressure.
// A strobe that arrives in a state that does not accept it is dropped.
// All outputs are registered and reflect the state entered on that edge.
module atm_session_ctrl #(
  parameter int CARD_W      = 6,
  parameter int PSW_W       = 16,
  parameter int BAL_W       = 20,
  parameter int USERS       = 10,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           card_in,
  input  logic [CARD_W-1:0]              card_number,
  input  logic                           card_out,
  input  logic                           psw_valid,
  input  logic [PSW_W-1:0]               psw_input,
  input  logic                           op_done,
  input  logic [BAL_W-1:0]               updated_balance,
  input  logic                           prov_we,
  input  logic [CARD_W-1:0]              prov_idx,
  input  logic [PSW_W-1:0]               prov_psw,
  input  logic [BAL_W-1:0]               prov_bal,
  output logic [BAL_W-1:0]               balance,
  output logic                           session_active,
  output logic                           pin_req,
  output logic [$clog2(MAX_TRIES+1)-1:0] attempts_left,
  output logic                           wrong_psw,
  output logic                           card_locked,
  output logic                           invalid_card,
  output logic                           eject,
  output logic [1:0]                     dbg_state
);

  localparam int IDX_W = (USERS > 1) ? $clog2(USERS) : 1;
  localparam int AW    = $clog2(MAX_TRIES + 1);
  localparam int TW    = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PIN    = 2'd1,
    S_ACTIVE = 2'd2,
    S_EJECT  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [USERS-1:0]     lock_q, lock_d;
  logic [AW-1:0]        att_q, att_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [BAL_W-1:0]     balance_q, balance_d;
  logic                 sa_q, sa_d, pr_q, pr_d;
  logic                 wp_q, wp_d, cl_q, cl_d;
  logic                 ic_q, ic_d, ej_q, ej_d;
  logic                 prov_wr, commit;

  // Account tables are not reset; they are loaded through prov_*.
  logic [PSW_W-1:0]     psw_mem [USERS];
  logic [BAL_W-1:0]     bal_mem [USERS];

  logic                 card_ok, prov_ok;
  logic [IDX_W-1:0]     card_idx, prov_i;

  assign card_ok  = card_number < CARD_W'(USERS);
  assign prov_ok  = prov_idx < CARD_W'(USERS);
  assign card_idx = card_number[IDX_W-1:0];
  assign prov_i   = prov_idx[IDX_W-1:0];

  // Next-state and next-output computation for the session FSM.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lock_d    = lock_q;
    att_d     = att_q;
    tmo_d     = tmo_q;
    balance_d = balance_q;
    wp_d      = 1'b0;
    cl_d      = 1'b0;
    ic_d      = 1'b0;
    ej_d      = 1'b0;
    prov_wr   = 1'b0;
    commit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (card_in) begin
          if (!card_ok) begin
            ic_d = 1'b1;
            ej_d = 1'b1;
          end else if (lock_q[card_idx]) begin
            cl_d = 1'b1;
            ej_d = 1'b1;
          end else begin
            idx_d   = card_idx;
            att_d   = AW'(MAX_TRIES);
            state_d = S_PIN;
          end
        end else if (prov_we && prov_ok) begin
          prov_wr        = 1'b1;
          lock_d[prov_i] = 1'b0;
        end
      end
      S_PIN: begin
        if (card_out) begin
          state_d = S_EJECT;
        end else if (psw_valid) begin
          tmo_d = '0;
          if (psw_input == psw_mem[idx_q]) begin
            state_d   = S_ACTIVE;
            balance_d = bal_mem[idx_q];
          end else begin
            wp_d  = 1'b1;
            att_d = att_q - AW'(1);
            if (att_q == AW'(1)) begin
              lock_d[idx_q] = 1'b1;
              cl_d          = 1'b1;
              state_d       = S_EJECT;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_EJECT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_ACTIVE: begin
        if (op_done) begin
          commit    = 1'b1;
          balance_d = updated_balance;
          tmo_d     = '0;
        end
        if (card_out) begin
          state_d = S_EJECT;
        end else if (!op_done) begin
          if (tmo_q == TMO_LAST) state_d = S_EJECT;
          else                   tmo_d   = tmo_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Counter restarts on every state entry; outputs track the next state.
    if (state_d != state_q) tmo_d = '0;
    if (state_d != S_ACTIVE) balance_d = '0;
    if (state_d != S_PIN) att_d = '0;
    if (state_d == S_EJECT) ej_d = 1'b1;
    sa_d = (state_d == S_ACTIVE);
    pr_d = (state_d == S_PIN);
  end

  // Session FSM state, counters, lock flags and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      lock_q    <= '0;
      att_q     <= '0;
      tmo_q     <= '0;
      balance_q <= '0;
      sa_q      <= 1'b0;
      pr_q      <= 1'b0;
      wp_q      <= 1'b0;
      cl_q      <= 1'b0;
      ic_q      <= 1'b0;
      ej_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lock_q    <= lock_d;
      att_q     <= att_d;
      tmo_q     <= tmo_d;
      balance_q <= balance_d;
      sa_q      <= sa_d;
      pr_q      <= pr_d;
      wp_q      <= wp_d;
      cl_q      <= cl_d;
      ic_q      <= ic_d;
      ej_q      <= ej_d;
    end
  end

  // Account table writes: provisioning in IDLE, balance commit in ACTIVE.
  always_ff @(posedge clk) begin
    if (prov_wr) begin
      psw_mem[prov_i] <= prov_psw;
      bal_mem[prov_i] <= prov_bal;
    end else if (commit) begin
      bal_mem[idx_q] <= updated_balance;
    end
  end

  assign balance        = balance_q;
  assign session_active = sa_q;
  assign pin_req        = pr_q;
  assign attempts_left  = att_q;
  assign wrong_psw      = wp_q;
  assign card_locked    = cl_q;
  assign invalid_card   = ic_q;
  assign eject          = ej_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl: a table of single-cycle vectors with
// hand-computed registered outputs, plus timeout and mid-session reset runs.
module tb_atm_session_ctrl;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        card_in = 1'b0, card_out = 1'b0, psw_valid = 1'b0;
  logic        op_done = 1'b0, prov_we = 1'b0;
  logic [5:0]  card_number = '0, prov_idx = '0;
  logic [15:0] psw_input = '0, prov_psw = '0;
  logic [19:0] updated_balance = '0, prov_bal = '0;
  logic [19:0] balance;
  logic        session_active, pin_req, wrong_psw, card_locked;
  logic        invalid_card, eject;
  logic [1:0]  attempts_left, dbg_state;
  logic [27:0] out_bus;

  int total = 0;
  int bad   = 0;
  logic [27:0] exp_q[$];

  atm_session_ctrl #(
    .CARD_W(6), .PSW_W(16), .BAL_W(20), .USERS(10),
    .MAX_TRIES(3), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .rst(rst),
    .card_in(card_in), .card_number(card_number), .card_out(card_out),
    .psw_valid(psw_valid), .psw_input(psw_input),
    .op_done(op_done), .updated_balance(updated_balance),
    .prov_we(prov_we), .prov_idx(prov_idx), .prov_psw(prov_psw),
    .prov_bal(prov_bal),
    .balance(balance), .session_active(session_active), .pin_req(pin_req),
    .attempts_left(attempts_left), .wrong_psw(wrong_psw),
    .card_locked(card_locked), .invalid_card(invalid_card), .eject(eject),
    .dbg_state(dbg_state)
  );

  assign out_bus = {balance, session_active, pin_req, attempts_left,
                    wrong_psw, card_locked, invalid_card, eject};

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ci;
    logic [5:0]  cn;
    logic        co;
    logic        pv;
    logic [15:0] pi;
    logic        od;
    logic [19:0] ub;
    logic        pw;
    logic [5:0]  px;
    logic [15:0] pp;
    logic [19:0] pb;
    logic [27:0] e;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [27:0] ex(logic [19:0] b, logic sa, logic pr,
                                     logic [1:0] at, logic wp, logic cl,
                                     logic ic, logic ej);
    return {b, sa, pr, at, wp, cl, ic, ej};
  endfunction

  function automatic vec_t mk(string nm, logic ci, logic [5:0] cn, logic co,
                              logic pv, logic [15:0] pi, logic od,
                              logic [19:0] ub, logic pw, logic [5:0] px,
                              logic [15:0] pp, logic [19:0] pb,
                              logic [27:0] e);
    vec_t v;
    v.name = nm; v.ci = ci; v.cn = cn; v.co = co; v.pv = pv; v.pi = pi;
    v.od = od; v.ub = ub; v.pw = pw; v.px = px; v.pp = pp; v.pb = pb;
    v.e = e;
    return v;
  endfunction

  function automatic vec_t nop(string nm, logic [27:0] e);
    return mk(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e);
  endfunction
  function automatic vec_t card(string nm, logic [5:0] n, logic [27:0] e);
    return mk(nm, 1, n, 0, 0, 0, 0, 0, 0, 0, 0, 0, e);
  endfunction
  function automatic vec_t pin(string nm, logic [15:0] p, logic [27:0] e);
    return mk(nm, 0, 0, 0, 1, p, 0, 0, 0, 0, 0, 0, e);
  endfunction
  function automatic vec_t cout(string nm, logic [27:0] e);
    return mk(nm, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, e);
  endfunction
  function automatic vec_t opd(string nm, logic [19:0] u, logic co,
                               logic [27:0] e);
    return mk(nm, 0, 0, co, 0, 0, 1, u, 0, 0, 0, 0, e);
  endfunction
  function automatic vec_t prov(string nm, logic [5:0] x, logic [15:0] p,
                                logic [19:0] b, logic [27:0] e);
    return mk(nm, 0, 0, 0, 0, 0, 0, 0, 1, x, p, b, e);
  endfunction

  // Driver tasks
  task automatic drive(vec_t v);
    card_in = v.ci; card_number = v.cn; card_out = v.co;
    psw_valid = v.pv; psw_input = v.pi; op_done = v.od;
    updated_balance = v.ub; prov_we = v.pw; prov_idx = v.px;
    prov_psw = v.pp; prov_bal = v.pb;
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, want);
    end
  endtask

  // Scoreboard step: drive one cycle, then compare registered outputs.
  task automatic step(vec_t v);
    logic [27:0] e;
    drive(v);
    exp_q.push_back(v.e);
    @(negedge clk);
    e = exp_q.pop_front();
    chk(v.name, {4'h0, out_bus}, {4'h0, e});
  endtask

  // Idle for n cycles; counts cycles where sel output is not high or eject fires.
  task automatic hold(string nm, int n, logic use_pin);
    int errs = 0;
    for (int i = 0; i < n; i++) begin
      drive(nop("h", '0));
      @(negedge clk);
      if ((use_pin ? !pin_req : !session_active) || eject) errs++;
    end
    chk(nm, errs, 0);
  endtask

  localparam logic [27:0] Z  = 28'h0;
  localparam logic [27:0] EJ = 28'h1;

  initial begin
    // Reset block
    drive(nop("init", Z));
    repeat (3) @(negedge clk);
    chk("reset_outputs", {4'h0, out_bus}, 32'h0);
    chk("reset_state", {30'h0, dbg_state}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Vector table
    vecs.push_back(prov("prov3", 3, 16'h1234, 500, Z));
    vecs.push_back(prov("prov5", 5, 16'hAAAA, 900, Z));
    vecs.push_back(prov("prov7", 7, 16'h0777, 50, Z));
    vecs.push_back(card("card3", 3, ex(0, 0, 1, 3, 0, 0, 0, 0)));
    vecs.push_back(pin("pin3_ok", 16'h1234, ex(500, 1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(nop("active_hold", ex(500, 1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(card("card_busy_ign", 5, ex(500, 1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(opd("op_420", 420, 0, ex(420, 1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(cout("eject3", EJ));
    vecs.push_back(nop("idle_a", Z));
    vecs.push_back(card("card3_again", 3, ex(0, 0, 1, 3, 0, 0, 0, 0)));
    vecs.push_back(pin("bal_420", 16'h1234, ex(420, 1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(opd("op77_cout", 77, 1, EJ));
    vecs.push_back(nop("idle_b", Z));
    vecs.push_back(card("card3_c", 3, ex(0, 0, 1, 3, 0, 0, 0, 0)));
    vecs.push_back(pin("bal_77", 16'h1234, ex(77, 1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(cout("eject3_c", EJ));
    vecs.push_back(nop("idle_c", Z));
    vecs.push_back(card("card5", 5, ex(0, 0, 1, 3, 0, 0, 0, 0)));
    vecs.push_back(pin("wrong1", 16'h0001, ex(0, 0, 1, 2, 1, 0, 0, 0)));
    vecs.push_back(pin("wrong2", 16'h0002, ex(0, 0, 1, 1, 1, 0, 0, 0)));
    vecs.push_back(pin("wrong3_lock", 16'h0003, ex(0, 0, 0, 0, 1, 1, 0, 1)));
    vecs.push_back(nop("idle_d", Z));
    vecs.push_back(card("card5_locked", 5, ex(0, 0, 0, 0, 0, 1, 0, 1)));
    vecs.push_back(nop("idle_e", Z));
    vecs.push_back(card("card12_inv", 12, ex(0, 0, 0, 0, 0, 0, 1, 1)));
    vecs.push_back(nop("idle_f", Z));
    vecs.push_back(card("card10_inv", 10, ex(0, 0, 0, 0, 0, 0, 1, 1)));
    vecs.push_back(card("card9_edge", 9, ex(0, 0, 1, 3, 0, 0, 0, 0)));
    vecs.push_back(cout("eject9", EJ));
    vecs.push_back(nop("idle_g", Z));
    vecs.push_back(prov("prov5_unlock", 5, 16'hAAAA, 900, Z));
    vecs.push_back(card("card5_open", 5, ex(0, 0, 1, 3, 0, 0, 0, 0)));
    vecs.push_back(mk("cout_beats_pin", 0, 0, 1, 1, 16'hAAAA, 0, 0, 0, 0, 0, 0,
                      EJ));
    vecs.push_back(nop("idle_h", Z));
    vecs.push_back(card("card5_b", 5, ex(0, 0, 1, 3, 0, 0, 0, 0)));
    vecs.push_back(pin("pin5_ok", 16'hAAAA, ex(900, 1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(prov("prov_busy_ign", 7, 16'h2222, 9, ex(900, 1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(cout("eject5", EJ));
    vecs.push_back(nop("idle_i", Z));
    vecs.push_back(mk("card_beats_prov", 1, 7, 0, 0, 0, 0, 0, 1, 7, 16'h1111, 5,
                      ex(0, 0, 1, 3, 0, 0, 0, 0)));
    vecs.push_back(pin("wrong7", 16'h1111, ex(0, 0, 1, 2, 1, 0, 0, 0)));
    vecs.push_back(pin("pin7_ok", 16'h0777, ex(50, 1, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(cout("eject7", EJ));
    vecs.push_back(nop("idle_j", Z));
    vecs.push_back(prov("prov_oob_ign", 12, 16'h3333, 1, Z));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Timeout in PIN_WAIT
    step(card("tmo_pin_card", 3, ex(0, 0, 1, 3, 0, 0, 0, 0)));
    hold("tmo_pin_hold", T - 1, 1'b1);
    step(nop("tmo_pin_eject", EJ));
    step(nop("tmo_pin_idle", Z));

    // Timeout in ACTIVE, restarted by op_done
    step(card("tmo_act_card", 3, ex(0, 0, 1, 3, 0, 0, 0, 0)));
    step(pin("tmo_act_pin", 16'h1234, ex(77, 1, 0, 0, 0, 0, 0, 0)));
    hold("tmo_act_hold1", T - 2, 1'b0);
    step(opd("tmo_act_op", 123, 0, ex(123, 1, 0, 0, 0, 0, 0, 0)));
    hold("tmo_act_hold2", T - 1, 1'b0);
    step(nop("tmo_act_eject", EJ));
    step(nop("tmo_act_idle", Z));

    // Reset in the middle of a session
    step(card("rst_card", 3, ex(0, 0, 1, 3, 0, 0, 0, 0)));
    step(pin("rst_pin", 16'h1234, ex(123, 1, 0, 0, 0, 0, 0, 0)));
    drive(nop("r", Z));
    rst = 1'b0;
    #1;
    chk("rst_async_out", {4'h0, out_bus}, 32'h0);
    chk("rst_async_state", {30'h0, dbg_state}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(nop("rst_no_eject", Z));
    step(card("rst_reinsert", 3, ex(0, 0, 1, 3, 0, 0, 0, 0)));
    step(pin("rst_bal_kept", 16'h1234, ex(123, 1, 0, 0, 0, 0, 0, 0)));
    step(cout("rst_eject", EJ));

    if (exp_q.size() != 0) chk("exp_q_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
